// File: rtl/pipe_logic_unit.sv
// rtl/pipe_logic_unit.sv - two-stage valid/ready bitwise logic unit with ZERO/ONES/PARITY flags
// Optional POPCNT output enabled by defining PIPE_LOGIC_UNIT_POPCNT_EN.
module pipe_logic_unit #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             ZERO,
    output logic             ONES,
`ifdef PIPE_LOGIC_UNIT_POPCNT_EN
    output logic             PARITY,
    output logic [$clog2(WIDTH+1)-1:0] POPCNT
`else
    output logic             PARITY
`endif
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_XNOR = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_PASB = 3'd7;

    logic             ready_en;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s2_valid;
    logic             s2_adv;
    logic             s2_take;
    logic             s1_load;
    logic [WIDTH-1:0] res;

    // ready_en keeps IN_READY low until the first edge after reset release
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign s2_adv    = !s2_valid || OUT_READY;
    assign s2_take   = s1_valid && s2_adv;
    assign IN_READY  = ready_en && (!s1_valid || s2_adv);
    assign s1_load   = IN_VALID && IN_READY;
    assign OUT_VALID = s2_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
        end else if (IN_READY) begin
            s1_valid <= IN_VALID;
        end
    end

    always_ff @(posedge CLK) begin
        if (s1_load) begin
            s1_a  <= A;
            s1_b  <= B;
            s1_op <= OP;
        end
    end

    always_comb begin
        res = '0;
        case (s1_op)
            OP_AND:  res = s1_a & s1_b;
            OP_OR:   res = s1_a | s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            OP_XNOR: res = ~(s1_a ^ s1_b);
            OP_NAND: res = ~(s1_a & s1_b);
            OP_NOR:  res = ~(s1_a | s1_b);
            OP_NOTA: res = ~s1_a;
            OP_PASB: res = s1_b;
            default: res = '0;
        endcase
    end

    // flags are computed from the same result that lands in OUT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_valid <= 1'b0;
            OUT      <= '0;
            ZERO     <= 1'b0;
            ONES     <= 1'b0;
            PARITY   <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_take) begin
                OUT    <= res;
                ZERO   <= ~|res;
                ONES   <= &res;
                PARITY <= ^res;
            end
        end
    end

`ifdef PIPE_LOGIC_UNIT_POPCNT_EN
    localparam int PCW = $clog2(WIDTH + 1);

    logic [PCW-1:0] res_cnt;

    always_comb begin
        res_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_cnt = res_cnt + PCW'(res[i]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            POPCNT <= '0;
        end else if (s2_take) begin
            POPCNT <= res_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_logic_unit.sv
// tb/tb_pipe_logic_unit.sv - directed self-checking bench for pipe_logic_unit (WIDTH=16)
// Also checks POPCNT when PIPE_LOGIC_UNIT_POPCNT_EN is defined.
module tb_pipe_logic_unit;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        zero;
    logic        ones;
    logic        parity;
`ifdef PIPE_LOGIC_UNIT_POPCNT_EN
    logic [4:0]  popcnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_ops [8];

    pipe_logic_unit #(.WIDTH(16)) dut (
        .CLK       (clk),
        .RST       (rst),
        .A         (a),
        .B         (b),
        .OP        (op),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OUT       (out),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .ZERO      (zero),
        .ONES      (ones),
`ifdef PIPE_LOGIC_UNIT_POPCNT_EN
        .PARITY    (parity),
        .POPCNT    (popcnt)
`else
        .PARITY    (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] vop);
        a = va;
        b = vb;
        op = vop;
        in_valid = 1'b1;
    endtask

    initial begin
        exp_ops[0] = 16'hF000;
        exp_ops[1] = 16'hFFF0;
        exp_ops[2] = 16'h0FF0;
        exp_ops[3] = 16'hF00F;
        exp_ops[4] = 16'h0FFF;
        exp_ops[5] = 16'h000F;
        exp_ops[6] = 16'h0F0F;
        exp_ops[7] = 16'hFF00;

        rst = 1'b1;
        a = '0;
        b = '0;
        op = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;

        // reset state
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_flags", {zero, ones, parity}, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rel_ready_before_edge", in_ready, 0);
        tick();
        chk("rst_rel_ready_after_edge", in_ready, 1);

        // single XNOR, latency
        drive(16'h0000, 16'h68AF, 3'd3);
        tick();
        in_valid = 1'b0;
        chk("lat_valid_early", out_valid, 0);
        tick();
        chk("xnor_valid", out_valid, 1);
        chk("xnor_out", out, 16'h9750);
        chk("xnor_parity", parity, 1);
        chk("xnor_zero", zero, 0);
        chk("xnor_ones", ones, 0);
`ifdef PIPE_LOGIC_UNIT_POPCNT_EN
        chk("xnor_popcnt", popcnt, 7);
`endif
        tick();
        chk("xnor_drain", out_valid, 0);

        // back-to-back pair
        drive(16'hFFFF, 16'hFF55, 3'd3);
        tick();
        drive(16'h0000, 16'hCCCC, 3'd3);
        tick();
        in_valid = 1'b0;
        chk("b2b_0_valid", out_valid, 1);
        chk("b2b_0_out", out, 16'hFF55);
        tick();
        chk("b2b_1_valid", out_valid, 1);
        chk("b2b_1_out", out, 16'h3333);
        tick();
        chk("b2b_drain", out_valid, 0);

        // all opcodes streamed one per cycle
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                drive(16'hF0F0, 16'hFF00, 3'(i));
                chk($sformatf("ops_ready_%0d", i), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk($sformatf("ops_valid_%0d", i - 1), out_valid, 1);
                chk($sformatf("ops_out_%0d", i - 1), out, exp_ops[i - 1]);
            end
        end
        tick();
        chk("ops_drain", out_valid, 0);

        // all-ones and all-zero flags
        drive(16'hFFFF, 16'hFFFF, 3'd0);
        tick();
        drive(16'hFFFF, 16'hFFFF, 3'd5);
        tick();
        in_valid = 1'b0;
        chk("ones_out", out, 16'hFFFF);
        chk("ones_flags", {zero, ones, parity}, 3'b010);
`ifdef PIPE_LOGIC_UNIT_POPCNT_EN
        chk("ones_popcnt", popcnt, 16);
`endif
        tick();
        chk("zero_out", out, 16'h0000);
        chk("zero_flags", {zero, ones, parity}, 3'b100);
        tick();

        // backpressure: three offered, two accepted
        out_ready = 1'b0;
        drive(16'h0000, 16'h1111, 3'd7);
        chk("bp_ready_0", in_ready, 1);
        tick();
        drive(16'h0000, 16'h2222, 3'd7);
        chk("bp_ready_1", in_ready, 1);
        tick();
        drive(16'h0000, 16'h3333, 3'd7);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_stall_ready_%0d", i), in_ready, 0);
            chk($sformatf("bp_stall_valid_%0d", i), out_valid, 1);
            chk($sformatf("bp_stall_out_%0d", i), out, 16'h1111);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_out_1", out, 16'h2222);
        chk("bp_valid_1", out_valid, 1);
        tick();
        chk("bp_out_2", out, 16'h3333);
        chk("bp_valid_2", out_valid, 1);
        tick();
        chk("bp_drain", out_valid, 0);

        // reset with both stages full
        out_ready = 1'b0;
        drive(16'hAAAA, 16'h5555, 3'd1);
        tick();
        drive(16'h1234, 16'h4321, 3'd2);
        tick();
        in_valid = 1'b0;
        chk("mid_full_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_out", out, 0);
        chk("mid_rst_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_rel_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mid_no_stale_%0d", i), out_valid, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
